// File: rtl/ad9226_capture_ctrl.sv
// rtl/ad9226_capture_ctrl.sv - AD9226 capture sequencer: arm, trigger, fill buffer, stream bytes
//
// Purpose: arms on start, optionally waits for a rising level crossing (or an
// auto-trigger timeout), fills a 2**ADDR_W x 12-bit buffer and then streams
// every sample as two bytes (high nibble first) over a valid/ready link.
// Optional feature macro: CAP_DECIM_EN (accept one sample every decim+1 clks).
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   adc_data[11:0]       registered ADC sample, new value every clk
//   start                1-cycle pulse, begins a capture run (IDLE only)
//   trig_en              1 = wait for level crossing, 0 = capture immediately
//   trig_level[11:0]     unsigned trigger threshold
//   decim[7:0]           decimation factor (CAP_DECIM_EN builds only)
//   tx_data[7:0]         byte to UART TX
//   tx_valid / tx_ready  byte handshake
//   busy                 high whenever state is not IDLE
//   done                 1-cycle pulse after the last byte is accepted
//   state[1:0]           0 IDLE, 1 ARMED, 2 CAPTURE, 3 READOUT
module ad9226_capture_ctrl #(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned TRIG_TO = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] adc_data,
   input  logic        start,
   input  logic        trig_en,
   input  logic [11:0] trig_level,
   input  logic [7:0]  decim,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        busy,
   output logic        done,
   output logic [1:0]  state
);

   localparam int unsigned       DEPTH     = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [23:0]       TO_LAST   = 24'(TRIG_TO - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED   = 2'd1,
      S_CAPTURE = 2'd2,
      S_READOUT = 2'd3
   } state_t;

   // Readout sub-sequence: issue RAM read, load high byte, send high, send low.
   typedef enum logic [1:0] {
      R_FETCH = 2'd0,
      R_LOAD  = 2'd1,
      R_HI    = 2'd2,
      R_LO    = 2'd3
   } phase_t;

   state_t            state_q, state_d;
   phase_t            phase_q, phase_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [23:0]       to_cnt_q, to_cnt_d;
   logic [11:0]       prev_q, prev_d;
   logic              first_q, first_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic              tx_valid_q, tx_valid_d;
   logic              done_q, done_d;

   logic              accept;
   logic              dec_restart;
   logic              trig_hit;
   logic              timeout;
   logic              mem_we;
   logic              mem_re;
   logic [11:0]       mem [DEPTH];
   logic [11:0]       rd_data_q;

`ifdef CAP_DECIM_EN
   logic [7:0] dec_cnt_q, dec_cnt_d;

   // ">=" rather than "==" keeps the counter sane if decim shrinks mid-run.
   always_comb begin
      dec_cnt_d = (dec_cnt_q >= decim) ? 8'd0 : dec_cnt_q + 8'd1;
      if (dec_restart) begin
         dec_cnt_d = 8'd0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dec_cnt_q <= 8'd0;
      end else begin
         dec_cnt_q <= dec_cnt_d;
      end
   end

   assign accept = (dec_cnt_q == 8'd0);
`else
   logic unused_decim;
   assign unused_decim = ^{decim, dec_restart};
   assign accept       = 1'b1;
`endif

   // The first accepted sample after entering ARMED only seeds prev.
   assign trig_hit = accept && !first_q &&
                     (prev_q < trig_level) && (adc_data >= trig_level);
   assign timeout  = (TRIG_TO != 0) && (to_cnt_q == TO_LAST);

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      addr_d     = addr_q;
      to_cnt_d   = 24'd0;
      prev_d     = prev_q;
      first_d    = first_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      done_d     = 1'b0;
      mem_we     = 1'b0;
      mem_re     = 1'b0;

      case (state_q)
         S_IDLE: begin
            addr_d     = '0;
            tx_valid_d = 1'b0;
            // done_q marks the cycle right after a run; start is ignored there.
            if (start && !done_q) begin
               first_d = 1'b1;
               state_d = trig_en ? S_ARMED : S_CAPTURE;
            end
         end

         S_ARMED: begin
            to_cnt_d = to_cnt_q + 24'd1;
            if (accept) begin
               prev_d  = adc_data;
               first_d = 1'b0;
            end
            if (trig_hit) begin
               // Triggering sample becomes index 0 on this same edge.
               mem_we  = 1'b1;
               addr_d  = addr_q + 1'b1;
               state_d = S_CAPTURE;
            end else if (timeout) begin
               state_d = S_CAPTURE;
            end
         end

         S_CAPTURE: begin
            if (accept) begin
               mem_we = 1'b1;
               addr_d = addr_q + 1'b1;
               if (addr_q == LAST_ADDR) begin
                  state_d = S_READOUT;
                  phase_d = R_FETCH;
               end
            end
         end

         S_READOUT: begin
            case (phase_q)
               R_FETCH: begin
                  mem_re  = 1'b1;
                  phase_d = R_LOAD;
               end
               R_LOAD: begin
                  tx_data_d  = {4'h0, rd_data_q[11:8]};
                  tx_valid_d = 1'b1;
                  phase_d    = R_HI;
               end
               R_HI: begin
                  // rd_data_q holds until the next fetch, so the low byte needs no copy.
                  if (tx_ready) begin
                     tx_data_d = rd_data_q[7:0];
                     phase_d   = R_LO;
                  end
               end
               default: begin
                  if (tx_ready) begin
                     tx_valid_d = 1'b0;
                     addr_d     = addr_q + 1'b1;
                     phase_d    = R_FETCH;
                     if (addr_q == LAST_ADDR) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                     end
                  end
               end
            endcase
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign dec_restart = (state_d != state_q) &&
                        ((state_d == S_ARMED) || (state_d == S_CAPTURE));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         phase_q    <= R_FETCH;
         addr_q     <= '0;
         to_cnt_q   <= 24'd0;
         prev_q     <= 12'd0;
         first_q    <= 1'b0;
         tx_data_q  <= 8'd0;
         tx_valid_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         addr_q     <= addr_d;
         to_cnt_q   <= to_cnt_d;
         prev_q     <= prev_d;
         first_q    <= first_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         done_q     <= done_d;
      end
   end

   // Single-port buffer: one address, writes only in ARMED/CAPTURE, reads only in READOUT.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[addr_q] <= adc_data;
      end
      if (mem_re) begin
         rd_data_q <= mem[addr_q];
      end
   end

   assign tx_data  = tx_data_q;
   assign tx_valid = tx_valid_q;
   assign busy     = (state_q != S_IDLE);
   assign done     = done_q;
   assign state    = state_q;

endmodule

// File: tb/tb_ad9226_capture_ctrl.sv
// tb/tb_ad9226_capture_ctrl.sv - self-checking bench for ad9226_capture_ctrl
module tb_ad9226_capture_ctrl;

   localparam int ADDR_W  = 4;
   localparam int DEPTH   = 16;
   localparam int TRIG_TO = 100;
`ifdef CAP_DECIM_EN
   localparam int DEC_ON = 1;
`else
   localparam int DEC_ON = 0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] adc_data = 12'd0;
   logic        start;
   logic        trig_en;
   logic [11:0] trig_level;
   logic [7:0]  decim;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b1;
   logic        busy;
   logic        done;
   logic [1:0]  state;

   ad9226_capture_ctrl #(.ADDR_W(ADDR_W), .TRIG_TO(TRIG_TO)) dut (
      .clk(clk), .rst(rst), .adc_data(adc_data), .start(start),
      .trig_en(trig_en), .trig_level(trig_level), .decim(decim),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .busy(busy), .done(done), .state(state)
   );

   always #5 clk = ~clk;

   int vecs = 0;
   int errs = 0;

   // Stimulus history: hist[k] is the adc_data value present at clock edge k.
   logic [11:0] hist [16384];
   int          cyc = 0;
   int          gen_mode = 0;
   logic [11:0] const_v = 12'd0, step_lo = 12'd0, step_hi = 12'd0;
   int          step_edge = 0;
   bit          rnd_ready = 1'b0;

   // Per-run model / monitor state
   int          t_start, m_s, exp_cap, cap_obs, nbytes, idle;
   bit          m_trig, model_done, cap_seen, done_pend, hold_pend, run_done, chk_en;
   logic [11:0] m_lvl, s_cur;
   logic [11:0] exp_s [DEPTH];
   logic [7:0]  rx [2*DEPTH];
   logic [7:0]  hold_data, exp_b;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
      vecs++;
      if (got !== want) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, got, want, cyc);
      end
   endtask

   function automatic logic [11:0] h(input int k);
      return hist[k & 16383];
   endfunction

   // Capture model: walk the recorded sample history edge by edge from the start edge.
   function automatic void build_model();
      int  k;
      bit  got, acc;
      logic [11:0] prev;
      if (!m_trig) begin
         exp_cap = t_start;
         for (int i = 0; i < DEPTH; i++) exp_s[i] = h(t_start + 1 + i * m_s);
         return;
      end
      got  = 1'b0;
      prev = 12'd0;
      k    = t_start + 1;
      while (!got && k <= t_start + TRIG_TO) begin
         acc = ((k - t_start - 1) % m_s) == 0;
         if (acc && k != t_start + 1 && prev < m_lvl && h(k) >= m_lvl) begin
            exp_cap  = k;
            exp_s[0] = h(k);
            for (int i = 1; i < DEPTH; i++) exp_s[i] = h(k + 1 + (i - 1) * m_s);
            got = 1'b1;
         end else if (k - t_start == TRIG_TO) begin
            exp_cap = k;
            for (int i = 0; i < DEPTH; i++) exp_s[i] = h(k + 1 + i * m_s);
            got = 1'b1;
         end
         if (acc) prev = h(k);
         k++;
      end
   endfunction

   // Sample generator and tx_ready driver (inputs change 1 time unit after the edge).
   always @(posedge clk) begin
      hist[cyc & 16383] = adc_data;
      cyc = cyc + 1;
      #1;
      case (gen_mode)
         0:       adc_data = 12'(cyc);
         1:       adc_data = const_v;
         2:       adc_data = (cyc < step_edge) ? step_lo : step_hi;
         default: adc_data = 12'($urandom);
      endcase
      tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Compare process, sampling away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         if (hold_pend) begin
            check("hold_valid", tx_valid, 1);
            check("hold_data", tx_data, hold_data);
         end
         check("done", done, done_pend);
         if (done_pend) begin
            check("end_state", state, 0);
            check("end_valid", tx_valid, 0);
            done_pend = 1'b0;
            run_done  = 1'b1;
         end
         check("busy", busy, state != 2'd0);
         if (state == 2'd2 && !cap_seen) begin
            cap_seen = 1'b1;
            cap_obs  = cyc - 1;
         end
         if (state == 2'd3 && !model_done) begin
            build_model();
            model_done = 1'b1;
            check("cap_edge", cap_obs, exp_cap);
         end
         if (state == 2'd3 && !tx_valid) begin
            idle++;
            if (idle > 2) check("gap", idle, 2);
         end else begin
            idle = 0;
         end
         if (tx_valid && tx_ready) begin
            if (nbytes >= 2 * DEPTH) begin
               check("extra_byte", nbytes, 2 * DEPTH - 1);
            end else if (!model_done) begin
               check("byte_before_readout", nbytes, 2 * DEPTH);
            end else begin
               s_cur = exp_s[nbytes / 2];
               exp_b = (nbytes % 2 == 1) ? s_cur[7:0] : {4'h0, s_cur[11:8]};
               check("byte", tx_data, exp_b);
               rx[nbytes] = tx_data;
            end
            nbytes++;
            if (nbytes == 2 * DEPTH) done_pend = 1'b1;
         end
         hold_pend = tx_valid && !tx_ready;
         hold_data = tx_data;
      end
   end

   task automatic run(input bit trig, input logic [11:0] lvl, input logic [7:0] dc,
                      input int stop_at, input bit start_at_done);
      int budget;
      trig_en    = trig;
      trig_level = lvl;
      decim      = dc;
      m_trig     = trig;
      m_lvl      = lvl;
      m_s        = (DEC_ON != 0) ? int'(dc) + 1 : 1;
      nbytes = 0; idle = 0; cap_obs = -1; exp_cap = -2;
      model_done = 0; cap_seen = 0; done_pend = 0; hold_pend = 0; run_done = 0;
      @(posedge clk); #2;
      start   = 1'b1;
      t_start = cyc;
      @(posedge clk); #2;
      start  = 1'b0;
      budget = 0;
      while (!run_done && !(stop_at >= 0 && nbytes > stop_at) && budget < 6000) begin
         if (start_at_done && done_pend) begin
            start = 1'b1;
            @(posedge clk); #2;
            start = 1'b0;
            check("start_during_done", state, 0);
         end
         @(posedge clk); #2;
         budget++;
      end
      if (budget >= 6000) check("run_timeout", budget, 0);
   endtask

   logic [11:0] tmp;

   initial begin
      rst = 1'b1; start = 1'b0; trig_en = 1'b0; trig_level = 12'd0; decim = 8'd0;
      chk_en = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("rst_state", state, 0);
      check("rst_valid", tx_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_data", tx_data, 0);
      rst    = 1'b0;
      chk_en = 1'b1;

      // Immediate capture of a ramp: samples t+1 .. t+16.
      gen_mode = 0;
      run(0, 12'd0, 8'd0, -1, 0);
      tmp = 12'(t_start + 1);
      check("ramp_b0", rx[0], {4'h0, tmp[11:8]});
      check("ramp_b1", rx[1], tmp[7:0]);
      tmp = 12'(t_start + 16);
      check("ramp_b31", rx[31], tmp[7:0]);

      // Level trigger: 1000 then 3000.
      gen_mode = 2; step_lo = 12'd1000; step_hi = 12'd3000; step_edge = cyc + 22;
      run(1, 12'd2048, 8'd0, -1, 0);
      check("trig_b0", rx[0], 8'h0B);
      check("trig_b1", rx[1], 8'hB8);
      check("trig_b30", rx[30], 8'h0B);
      check("trig_b31", rx[31], 8'hB8);

      // Random data, random backpressure.
      gen_mode = 3; rnd_ready = 1'b1;
      run(0, 12'd0, 8'd0, -1, 0);
      check("bp_count", nbytes, 32);

      // Auto-trigger timeout with a level that is never crossed.
      gen_mode = 1; const_v = 12'd100; rnd_ready = 1'b0;
      run(1, 12'd2048, 8'd0, -1, 0);
      check("timeout_edge", cap_obs - t_start, 100);
      check("timeout_b1", rx[1], 8'd100);

      // Reset in the middle of readout, then a full run with start during done.
      gen_mode = 0;
      run(0, 12'd0, 8'd0, 5, 0);
      #1 rst = 1'b1;
      chk_en = 1'b0;
      #1;
      check("midrst_state", state, 0);
      check("midrst_valid", tx_valid, 0);
      check("midrst_busy", busy, 0);
      @(posedge clk); #2;
      rst    = 1'b0;
      chk_en = 1'b1;
      run(0, 12'd0, 8'd0, -1, 1);
      check("after_rst_count", nbytes, 32);

      // Decimation by 4 (spacing 1 when the feature is compiled out).
      gen_mode = 0;
      run(0, 12'd0, 8'd3, -1, 0);
      tmp = 12'(t_start + 1 + ((DEC_ON != 0) ? 4 : 1));
      check("decim_b3", rx[3], tmp[7:0]);

      // Randomized runs.
      for (int r = 0; r < 8; r++) begin
         gen_mode  = 3;
         rnd_ready = 1'($urandom_range(0, 1));
         run(1'($urandom_range(0, 1)), 12'($urandom), 8'($urandom_range(0, 3)), -1, 0);
         check("rand_count", nbytes, 32);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
